init_sequencer: RTL and testbench
=================================

INIT_SEQUENCER -- requirements
Module: init_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_ENTRIES, default 512, meaning the number of init memory words and the hard stop for the address counter.
REQ-002 The block SHALL have parameter MAX_RETRY, default 3, meaning the number of NACK retries per entry before abort.
REQ-003 The block SHALL have parameter DELAY_TICK, default 27000, meaning the clk cycles per delay unit (1 ms at 27 MHz).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low (clk, reset_n).
REQ-005 The block SHALL have these ports, in order:
- clk  in  1  system clock
- reset_n  in  1  async active-low reset
- start  in  1  one-cycle pulse that begins the sequence
- mem_addr  out  12  init memory read address
- mem_data  in  24  init memory read data, valid 1 cycle after mem_addr
- i2c_req  out  1  write request to the I2C master
- i2c_dev  out  8  device address byte
- i2c_reg  out  8  register address
- i2c_wdata  out  8  write data
- i2c_done  in  1  pulse: transfer finished
- i2c_nack  in  1  qualifies i2c_done: transfer NACKed
- busy  out  1  sequence in progress
- done  out  1  sequence completed, sticky
- error  out  1  sequence aborted, sticky
- err_index  out  12  entry index at abort

Function
REQ-006 Entry format SHALL be [23:16] device, [15:8] register, [7:0] data.
REQ-007 A device byte of 0xFF SHALL be an end marker and 0xFE SHALL be a delay entry; all other values SHALL be I2C writes.
REQ-008 The FSM states SHALL be IDLE, FETCH, WAIT_RD, DECODE, ISSUE, WAIT_I2C, DELAY, DONE, ERROR.
REQ-009 IDLE SHALL go to FETCH on start, clearing the index to 0, the retry count to 0, done and error. start SHALL be ignored in every other state.
REQ-010 FETCH SHALL drive mem_addr=index, WAIT_RD SHALL absorb the 1-cycle RAM latency, and DECODE SHALL register mem_data.
REQ-011 DECODE SHALL go: end marker -> DONE; delay entry -> DELAY; write -> ISSUE.
REQ-012 ISSUE SHALL assert i2c_req with dev/reg/wdata stable, holding them until i2c_done; i2c_req SHALL then go low the cycle after i2c_done.
REQ-013 On i2c_done with i2c_nack=0, the block SHALL increment index, clear the retry count, and go to FETCH.
REQ-014 On i2c_done with i2c_nack=1, the block SHALL re-ISSUE if retry < MAX_RETRY (retry++); otherwise it SHALL go to ERROR with err_index=index.
REQ-015 DELAY SHALL wait data*DELAY_TICK cycles, then increment index and go to FETCH; data=0 SHALL advance after 1 cycle.
REQ-016 If the index reaches NUM_ENTRIES with no end marker, the block SHALL go to DONE.
REQ-017 DONE SHALL set done=1 and ERROR SHALL set error=1; both SHALL return to IDLE the next cycle, with the flag held until the next start.
REQ-018 busy SHALL be 1 in every state except IDLE.
REQ-019 i2c_done arriving outside WAIT_I2C SHALL be ignored.
REQ-020 Write-entry throughput SHALL be 4 cycles of overhead plus the I2C transfer time.

Reset
REQ-021 While reset_n=0, the block SHALL be in IDLE with all outputs 0, the index, retry and delay counters 0, and err_index 0.
REQ-022 Reset mid-sequence SHALL abort immediately and SHALL drop i2c_req with no completion.

Structure
REQ-023 A shared package SHALL hold the state enum, the marker constants (END=0xFF, DELAY=0xFE) and the entry field bit positions.
REQ-024 The delay counter SHALL be the only sub-module: delay_timer (load, count, expire pulse).

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Memory {0x98_FF_80, 0x98_F4_80, 0xFF_00_00}, all ACK -> two writes in order, done=1, error=0.
- Entry 0 NACKed 2 times, then ACK (MAX_RETRY=3) -> 3 i2c_req for entry 0, then done=1.
- Entry 1 always NACKs -> 4 attempts, error=1, err_index=1, done=0.
- Entry {0xFE,0x00,0x02}, DELAY_TICK=10 -> next mem_addr change occurs 20 cycles after DECODE.
- reset_n low during WAIT_I2C -> i2c_req=0 and busy=0 immediately; a later start restarts at index 0.
- Memory with no end marker, NUM_ENTRIES=4 -> four writes, then done=1.

Source files
------------

// File: rtl/init_sequencer_pkg.sv
// Shared types and constants for the init-table sequencer: FSM states,
// entry markers and the bit layout of a 24-bit init memory word.
package init_sequencer_pkg;

   typedef enum logic [3:0] {
      IDLE,
      FETCH,
      WAIT_RD,
      DECODE,
      ISSUE,
      WAIT_I2C,
      DELAY,
      DONE,
      ERROR
   } state_t;

   localparam logic [7:0] DEV_END   = 8'hFF;
   localparam logic [7:0] DEV_DELAY = 8'hFE;

   localparam int DEV_MSB = 23;
   localparam int DEV_LSB = 16;
   localparam int REG_MSB = 15;
   localparam int REG_LSB = 8;
   localparam int DAT_MSB = 7;
   localparam int DAT_LSB = 0;

   localparam int IDX_W   = 12;
   localparam int ENTRY_W = 24;
   localparam int TMR_W   = 32;

endpackage

// File: rtl/init_sequencer_delay_timer.sv
// Down-counting delay timer: load a terminal count, count down while enabled,
// pulse expire on the cycle the count sits at zero.
module delay_timer
   import init_sequencer_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [TMR_W-1:0] load_val,
   input  logic             count,
   output logic             expire
);

   logic [TMR_W-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (count && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   // a loaded value of N yields N+1 counting cycles
   assign expire = count && (cnt == '0);

endmodule

// File: rtl/init_sequencer.sv
// Walks an init memory table and issues I2C register writes, delays and an
// end marker; retries NACKed writes and reports completion or abort.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   IDLE     | waiting for start; done/error flags held
//   FETCH    | mem_addr = index presented to the init memory
//   WAIT_RD  | absorb the one-cycle memory read latency
//   DECODE   | register the entry and classify it
//   ISSUE    | launch an I2C write request
//   WAIT_I2C | hold the request until i2c_done
//   DELAY    | count data*DELAY_TICK cycles
//   DONE     | sequence finished, set done
//   ERROR    | retries exhausted, set error
module init_sequencer
   import init_sequencer_pkg::*;
#(
   parameter int NUM_ENTRIES = 512,
   parameter int MAX_RETRY   = 3,
   parameter int DELAY_TICK  = 27000
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   output logic [IDX_W-1:0]   mem_addr,
   input  logic [ENTRY_W-1:0] mem_data,
   output logic               i2c_req,
   output logic [7:0]         i2c_dev,
   output logic [7:0]         i2c_reg,
   output logic [7:0]         i2c_wdata,
   input  logic               i2c_done,
   input  logic               i2c_nack,
   output logic               busy,
   output logic               done,
   output logic               error,
   output logic [IDX_W-1:0]   err_index
);

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   index;
   logic [7:0]         retry;
   logic [ENTRY_W-1:0] entry_q;
   logic               done_q, error_q, rearm;
   logic [IDX_W-1:0]   err_index_q;

   logic               timer_load, timer_count, timer_expire;
   logic [TMR_W-1:0]   timer_load_val;
   logic [7:0]         dly_units;
   logic               can_retry;

   assign dly_units = mem_data[DAT_MSB:DAT_LSB];
   assign can_retry = retry < 8'(MAX_RETRY);

   delay_timer u_delay_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (timer_load),
      .load_val (timer_load_val),
      .count    (timer_count),
      .expire   (timer_expire)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt      = state;
      timer_load     = 1'b0;
      timer_count    = 1'b0;
      timer_load_val = '0;
      case (state)
         IDLE:     if (start) state_nxt = FETCH;
         FETCH:    state_nxt = ({20'd0, index} >= 32'(NUM_ENTRIES)) ? DONE : WAIT_RD;
         WAIT_RD:  state_nxt = DECODE;
         DECODE: begin
            if (mem_data[DEV_MSB:DEV_LSB] == DEV_END) begin
               state_nxt = DONE;
            end else if (mem_data[DEV_MSB:DEV_LSB] == DEV_DELAY) begin
               state_nxt      = DELAY;
               timer_load     = 1'b1;
               timer_load_val = (dly_units == 8'd0) ? '0 :
                                TMR_W'(dly_units) * TMR_W'(DELAY_TICK) - TMR_W'(1);
            end else begin
               state_nxt = ISSUE;
            end
         end
         ISSUE:    state_nxt = WAIT_I2C;
         WAIT_I2C: begin
            if (i2c_done) begin
               if (!i2c_nack)      state_nxt = FETCH;
               else if (can_retry) state_nxt = ISSUE;
               else                state_nxt = ERROR;
            end
         end
         DELAY: begin
            timer_count = 1'b1;
            if (timer_expire) state_nxt = FETCH;
         end
         DONE:     state_nxt = IDLE;
         ERROR:    state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         index       <= '0;
         retry       <= '0;
         entry_q     <= '0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         rearm       <= 1'b0;
         err_index_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  index       <= '0;
                  retry       <= '0;
                  done_q      <= 1'b0;
                  error_q     <= 1'b0;
                  err_index_q <= '0;
               end
            end
            DECODE: entry_q <= mem_data;
            ISSUE:  rearm   <= 1'b0;
            WAIT_I2C: begin
               if (i2c_done) begin
                  if (!i2c_nack) begin
                     index <= index + 1'b1;
                     retry <= '0;
                  end else if (can_retry) begin
                     retry <= retry + 1'b1;
                     rearm <= 1'b1;
                  end else begin
                     err_index_q <= index;
                  end
               end
            end
            DELAY:   if (timer_expire) index <= index + 1'b1;
            DONE:    done_q  <= 1'b1;
            ERROR:   error_q <= 1'b1;
            default: ;
         endcase
      end
   end

   // a retry's ISSUE cycle keeps i2c_req low so every attempt shows a fresh request edge
   assign i2c_req   = ((state == ISSUE) && !rearm) || (state == WAIT_I2C);
   assign i2c_dev   = entry_q[DEV_MSB:DEV_LSB];
   assign i2c_reg   = entry_q[REG_MSB:REG_LSB];
   assign i2c_wdata = entry_q[DAT_MSB:DAT_LSB];
   assign mem_addr  = index;
   assign busy      = (state != IDLE);
   assign done      = done_q;
   assign error     = error_q;
   assign err_index = err_index_q;

endmodule

// File: tb/tb_init_sequencer.sv
// Directed bench for init_sequencer: behavioural init memory, an I2C responder
// with a per-entry NACK plan, and a write scoreboard.
module tb_init_sequencer;

   localparam int NE = 4;
   localparam int MR = 3;
   localparam int DT = 10;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [11:0] mem_addr;
   logic [23:0] mem_data = '0;
   logic        i2c_req;
   logic [7:0]  i2c_dev, i2c_reg, i2c_wdata;
   logic        i2c_done = 1'b0;
   logic        i2c_nack = 1'b0;
   logic        busy, done, error;
   logic [11:0] err_index;

   init_sequencer #(.NUM_ENTRIES(NE), .MAX_RETRY(MR), .DELAY_TICK(DT)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .i2c_req   (i2c_req),
      .i2c_dev   (i2c_dev),
      .i2c_reg   (i2c_reg),
      .i2c_wdata (i2c_wdata),
      .i2c_done  (i2c_done),
      .i2c_nack  (i2c_nack),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .err_index (err_index)
   );

   always #5 clk = ~clk;

   logic [23:0] mem [0:15];
   always @(posedge clk) mem_data <= mem[mem_addr[3:0]];

   int cyc = 0;
   always @(posedge clk) cyc++;

   int          n_checks = 0;
   int          n_fail = 0;
   logic [23:0] exp_q[$];
   int          nack_left [0:15];
   int          attempts  [0:15];
   int          hold_idx = -1;
   bit          gap_chk = 1'b0;
   int          last_done = -1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // I2C slave model: answers each request after a short latency
   initial begin : responder
      int          idx;
      int          lat;
      logic [23:0] got, want;
      forever begin
         @(negedge clk);
         if (i2c_req === 1'b1) begin
            idx = int'(mem_addr[3:0]);
            attempts[idx]++;
            if (gap_chk && last_done >= 0) check("req_gap", cyc - last_done, 4);
            if (idx == hold_idx) begin
               while (i2c_req === 1'b1) @(negedge clk);
            end else begin
               lat = 1 + (attempts[idx] % 3);
               repeat (lat) @(negedge clk);
               got      = {i2c_dev, i2c_reg, i2c_wdata};
               i2c_done = 1'b1;
               i2c_nack = (nack_left[idx] != 0);
               if (nack_left[idx] > 0) nack_left[idx]--;
               if (i2c_nack) begin
                  check("nack_fields", got, mem[idx]);
               end else begin
                  want = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hxxxxxx;
                  check("write", got, want);
               end
               last_done = cyc;
               @(negedge clk);
               i2c_done = 1'b0;
               i2c_nack = 1'b0;
            end
         end
      end
   end

   task automatic setup(input logic [23:0] m0, input logic [23:0] m1,
                        input logic [23:0] m2, input logic [23:0] m3);
      for (int i = 0; i < 16; i++) begin
         mem[i]       = 24'h98_55_55;
         nack_left[i] = 0;
         attempts[i]  = 0;
      end
      mem[0] = m0; mem[1] = m1; mem[2] = m2; mem[3] = m3;
      exp_q.delete();
      last_done = -1;
   endtask

   task automatic push_writes(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(mem[i]);
   endtask

   task automatic start_seq(input string tag);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      check({tag, "_start_flags"}, {busy, done, error}, 3'b100);
      check({tag, "_start_addr"}, mem_addr, 0);
   endtask

   task automatic wait_idle(input string tag, input int limit);
      int k = 0;
      while (busy === 1'b1 && k < limit) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_idle"}, busy, 0);
   endtask

   initial begin : main
      int c0, c2, k;
      setup(24'hFF0000, 24'hFF0000, 24'hFF0000, 24'hFF0000);

      repeat (2) @(negedge clk);
      check("rst_flags", {i2c_req, busy, done, error}, 4'b0000);
      check("rst_addr", mem_addr, 0);
      check("rst_fields", {i2c_dev, i2c_reg, i2c_wdata}, 0);
      check("rst_err_index", err_index, 0);
      reset_n = 1'b1;
      @(negedge clk);

      // two ACKed writes then end marker
      setup(24'h98FF80, 24'h98F480, 24'hFF0000, 24'h985555);
      gap_chk = 1'b1;
      push_writes(2);
      start_seq("s1");
      wait_idle("s1", 500);
      gap_chk = 1'b0;
      check("s1_done_err", {done, error}, 2'b10);
      check("s1_sb_empty", exp_q.size(), 0);
      check("s1_attempts0", attempts[0], 1);
      check("s1_attempts1", attempts[1], 1);

      // entry 0 NACKed twice, third try ACKed
      setup(24'h98FF80, 24'h98F480, 24'hFF0000, 24'h985555);
      nack_left[0] = 2;
      push_writes(2);
      start_seq("s2");
      wait_idle("s2", 500);
      check("s2_attempts0", attempts[0], 3);
      check("s2_done_err", {done, error}, 2'b10);
      check("s2_sb_empty", exp_q.size(), 0);

      // entry 1 always NACKs
      setup(24'h98FF80, 24'h98F480, 24'hFF0000, 24'h985555);
      nack_left[1] = -1;
      push_writes(1);
      start_seq("s3");
      wait_idle("s3", 500);
      check("s3_attempts1", attempts[1], 4);
      check("s3_done_err", {done, error}, 2'b01);
      check("s3_err_index", err_index, 1);
      check("s3_sb_empty", exp_q.size(), 0);

      // delay entries: 2 units and 0 units
      setup(24'hFE0002, 24'h981001, 24'hFE0000, 24'hFF0000);
      exp_q.push_back(mem[1]);
      start_seq("s4");
      c0 = 0; c2 = 0; k = 0;
      while (busy === 1'b1 && k < 500) begin
         if (mem_addr == 12'd0) c0++;
         if (mem_addr == 12'd2) c2++;
         @(negedge clk);
         k++;
      end
      check("s4_idle", busy, 0);
      check("s4_delay2_cycles", c0, 3 + 2 * DT);
      check("s4_delay0_cycles", c2, 3 + 1);
      check("s4_done", done, 1);
      check("s4_sb_empty", exp_q.size(), 0);

      // reset while entry 1 is waiting on the bus
      setup(24'h981001, 24'h982002, 24'hFF0000, 24'hFF0000);
      hold_idx = 1;
      push_writes(1);
      start_seq("s5");
      k = 0;
      while (!(i2c_req === 1'b1 && mem_addr == 12'd1) && k < 500) begin
         @(negedge clk);
         k++;
      end
      check("s5_reached_entry1", {i2c_req, mem_addr}, {1'b1, 12'd1});
      reset_n = 1'b0;
      #1;
      check("s5_rst_req_busy", {i2c_req, busy}, 2'b00);
      check("s5_rst_addr", mem_addr, 0);
      check("s5_sb_empty", exp_q.size(), 0);
      @(negedge clk);
      reset_n  = 1'b1;
      hold_idx = -1;
      push_writes(2);
      start_seq("s5r");
      wait_idle("s5r", 500);
      check("s5r_attempts0", attempts[0], 2);
      check("s5r_done_err", {done, error}, 2'b10);
      check("s5r_sb_empty", exp_q.size(), 0);

      // no end marker: stops at NUM_ENTRIES
      setup(24'h981001, 24'h982002, 24'h983003, 24'h984004);
      push_writes(4);
      start_seq("s6");
      wait_idle("s6", 800);
      check("s6_done_err", {done, error}, 2'b10);
      check("s6_sb_empty", exp_q.size(), 0);
      check("s6_attempts4", attempts[4], 0);
      check("s6_stop_index", mem_addr, NE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
